axis_rng_arbiter: RTL
=====================

# axis_rng_arbiter

Shares one 32-bit AXI-Stream random-number source, such as the MT19937 generator, between `PORTS` consumers using round-robin bursts, and sequences reseeding of that source. It sits between the generator's output stream and the consumers. It also owns the generator's `seed_val`/`seed_start`/`busy` configuration interface, so every seed operation is arbitrated against data delivery.

## Interface
- `PORTS`, 4: number of consumer ports (2–16).
- `BURST_LEN`, 8: maximum words delivered per grant (1–255).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `input_axis_tdata`  in  32  word from the generator.
- `input_axis_tvalid`  in  1  generator word valid.
- `input_axis_tready`  out  1  accept generator word.
- `req`  in  PORTS  per-consumer level request for words.
- `output_axis_tdata`  out  32  word, shared by all ports.
- `output_axis_tvalid`  out  PORTS  one-hot valid; port i owns the word when bit i is set.
- `output_axis_tready`  in  PORTS  per-consumer ready.
- `seed_req`  in  1  one-cycle pulse requesting a reseed.
- `seed_val`  in  32  seed value, sampled with `seed_req`.
- `seed_ack`  out  1  one-cycle pulse when the reseed is complete.
- `rng_seed_val`  out  32  seed value driven to the generator.
- `rng_seed_start`  out  1  seed strobe driven to the generator.
- `rng_busy`  in  1  generator busy.
- `grant_valid`  out  1  a consumer currently holds the grant.
- `grant_port`  out  4  index of the granted consumer.
- `busy`  out  1  reseed pending or in progress.

## Operation
- **Output register:** single stage holding `out_data`, `out_valid` and `out_port`. `output_axis_tvalid[i] = out_valid && out_port==i`. The register clears when the owning port's tready is high; it loads on an upstream handshake.
- **Seed latch:** `seed_req` sets `seed_pend` and captures `seed_val` into `seed_hold`. A later `seed_req` before `SEED_ISSUE` overwrites `seed_hold`, so the latest value wins. A `seed_req` arriving during `SEED_WAIT` re-arms `seed_pend`, and a second reseed follows.
- **`IDLE`:**
  - If `seed_pend`, go to `SEED_ISSUE`. Seed has priority over grants.
  - Otherwise, if any `req` is set, grant the first requester searching upward from `rr_ptr` with wrap. Load `cnt=BURST_LEN`, set `rr_ptr = granted+1 mod PORTS`, and go to `GRANT`.
- **`GRANT`:**
  - `stop = (cnt==0) || !req[g] || seed_pend`.
  - `input_axis_tready = !stop && (!out_valid || output_axis_tready[out_port])`. This is combinational from the consumer's tready, which gives 1 word/cycle.
  - Each upstream handshake loads the register with `out_port=g` and decrements `cnt`.
  - When `stop` is true, go to `DRAIN`.
- **`DRAIN`:** `input_axis_tready=0`. Return to `IDLE` once `out_valid` is 0 or is being consumed this cycle.
- **`SEED_ISSUE`:**
  - `rng_seed_start=1` for exactly one cycle, with `rng_seed_val=seed_hold`.
  - Clear `seed_pend`, unless a new `seed_req` arrives this cycle.
  - Go to `SEED_WAIT`.
- **`SEED_WAIT`:**
  - `input_axis_tready=1`. Any stale generator word is discarded and never reaches a consumer.
  - When `rng_busy==0`, pulse `seed_ack` and go to `IDLE`.
  - `rng_busy` is guaranteed high in the first `SEED_WAIT` cycle, because the generator registers busy from the seed strobe.
- **Outputs by state:**
  - `grant_valid` is 1 in `GRANT` only; `grant_port` holds the last granted index.
  - `busy = seed_pend || state in {SEED_ISSUE, SEED_WAIT}`.
  - `rng_seed_val` holds its value between strobes.
- **Request behaviour:** a `req` drop mid-burst ends the burst after any in-flight word. A word already in the output register is always delivered to its port and is never redirected. Non-granted ports never see tvalid.

## Timing
- **Reset values:** state `IDLE`, `rr_ptr=0`, `out_valid=0`, all `output_axis_tvalid=0`, `output_axis_tdata=0`, `input_axis_tready=0`, `rng_seed_start=0`, `rng_seed_val=0`, `seed_ack=0`, `seed_pend=0`, `busy=0`, `grant_valid=0`, `grant_port=0`.
- Reset asserted mid-burst or mid-seed returns everything to reset values immediately. An interrupted generator seed is the generator's concern.
- **Grant latency:** req in cycle N gives `GRANT` in N+1; the first upstream handshake can occur in N+1; the word is visible at the consumer in N+2.
- **Burst:** at most `BURST_LEN` upstream handshakes per grant. `DRAIN` lasts at least 1 cycle, then `IDLE` for 1 cycle before the next grant.
- **Seed latency:**
  - `seed_req` in cycle N, with the block in `IDLE`: `seed_pend`/`busy` high from N+1, `rng_seed_start` in N+2, `SEED_WAIT` from N+3.
  - `seed_ack` occurs in the first cycle `SEED_WAIT` sees `rng_busy==0`.
- `seed_req` and `req` arriving in the same cycle: the seed is served first.
- **Round-robin fairness:** every continuously requesting port is granted within `PORTS` grants.

## Test plan
- **Single requester:** PORTS=4, BURST_LEN=4, `req=0001`, source streams 1,2,3,…; all ready → port 0 receives 1,2,3,4. A gap of `DRAIN` + `IDLE` follows, then 5,6,7,8. No other tvalid bit is ever set.
- **Round robin:** `req=1111` held, always ready → grants in order 0,1,2,3,0. Each burst carries exactly 4 consecutive source words, and no word is lost or duplicated.
- **Backpressure:** port 2 granted, tready toggling 1,0,0,1 → `input_axis_tready` follows it. tdata is stable while tvalid is high and tready low. Delivered sequence is complete and in order.
- **Request drop:** port 1 deasserts `req` after its 2nd word → burst ends after 2 words. The in-flight word is still delivered to port 1, and the next grant goes to port 2.
- **Mid-burst reseed:** `seed_req` with `seed_val=0x12345678` during a burst → burst stops and drains. `rng_seed_start` pulses once with `rng_seed_val=0x12345678`. `seed_ack` pulses after `rng_busy` falls, and the first delivered word afterwards is the generator's first output for that seed (0xC6979343).
- **Reset mid-operation:** assert `rst_n=0` during `SEED_WAIT` with `out_valid=1` → all outputs take reset values asynchronously. After release, `req=0100` is granted port 2 first.

Source files
------------

// File: rtl/axis_rng_arbiter.sv
// Round-robin burst arbiter sharing one 32-bit AXI-Stream RNG source among PORTS consumers.
// Also sequences reseeds of the generator, which take priority over data grants.
module axis_rng_arbiter #(
  parameter int PORTS     = 4,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       input_axis_tdata,
  input  logic              input_axis_tvalid,
  output logic              input_axis_tready,
  input  logic [PORTS-1:0]  req,
  output logic [31:0]       output_axis_tdata,
  output logic [PORTS-1:0]  output_axis_tvalid,
  input  logic [PORTS-1:0]  output_axis_tready,
  input  logic              seed_req,
  input  logic [31:0]       seed_val,
  output logic              seed_ack,
  output logic [31:0]       rng_seed_val,
  output logic              rng_seed_start,
  input  logic              rng_busy,
  output logic              grant_valid,
  output logic [3:0]        grant_port,
  output logic              busy
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] GRANT      = 3'd1;
  localparam logic [2:0] DRAIN      = 3'd2;
  localparam logic [2:0] SEED_ISSUE = 3'd3;
  localparam logic [2:0] SEED_WAIT  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] rr_ptr, g, out_port, pick;
  logic          pick_vld;
  logic [7:0]    cnt;
  logic [31:0]   out_data, seed_hold, seed_last;
  logic          out_valid, seed_pend;
  logic          stop, out_take, in_hs;

  // Search upward from rr_ptr with wrap; iterating from the far end lets the nearest requester win.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (req[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign out_take = out_valid && output_axis_tready[out_port];
  assign stop     = (cnt == 8'd0) || !req[g] || seed_pend;

  always_comb begin
    input_axis_tready = 1'b0;
    case (state)
      GRANT:     input_axis_tready = !stop && (!out_valid || out_take);
      SEED_WAIT: input_axis_tready = 1'b1;  // flush stale words from the reseeding generator
      default:   input_axis_tready = 1'b0;
    endcase
  end

  assign in_hs = input_axis_tvalid && input_axis_tready && (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      g         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      seed_pend <= 1'b0;
      seed_hold <= '0;
      seed_last <= '0;
    end else begin
      // A request landing in SEED_ISSUE keeps pend set so a second reseed follows.
      if (seed_req) begin
        seed_pend <= 1'b1;
        seed_hold <= seed_val;
      end else if (state == SEED_ISSUE) begin
        seed_pend <= 1'b0;
      end

      if (in_hs) begin
        out_valid <= 1'b1;
        out_data  <= input_axis_tdata;
        out_port  <= g;
        cnt       <= cnt - 8'd1;
      end else if (out_take) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (seed_pend) begin
            state <= SEED_ISSUE;
          end else if (pick_vld) begin
            g      <= pick;
            cnt    <= 8'(BURST_LEN);
            rr_ptr <= (pick == PW'(PORTS - 1)) ? '0 : pick + 1'b1;
            state  <= GRANT;
          end
        end
        GRANT:      if (stop) state <= DRAIN;
        DRAIN:      if (!out_valid || out_take) state <= IDLE;
        SEED_ISSUE: begin
          seed_last <= seed_hold;
          state     <= SEED_WAIT;
        end
        SEED_WAIT:  if (!rng_busy) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    output_axis_tvalid = '0;
    for (int i = 0; i < PORTS; i++)
      output_axis_tvalid[i] = out_valid && (int'(out_port) == i);
  end

  assign output_axis_tdata = out_data;
  assign rng_seed_start    = (state == SEED_ISSUE);
  assign rng_seed_val      = rng_seed_start ? seed_hold : seed_last;
  assign seed_ack          = (state == SEED_WAIT) && !rng_busy;
  assign grant_valid       = (state == GRANT);
  assign grant_port        = 4'(g);
  assign busy              = seed_pend || (state == SEED_ISSUE) || (state == SEED_WAIT);

endmodule
